// File: rtl/mii_frame_rx_if.sv
// MII receive pins plus the byte stream and frame verdict of mii_frame_rx, bundled as one interface.
// board_mac exists only when MII_RX_MAC_FILTER_EN is defined.
interface mii_frame_rx_if;
    logic        rxdv;
    logic        rxer;
    logic [3:0]  datain;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_sof;
    logic        rx_done;
    logic        frame_good;
    logic        frame_bad;
    logic [10:0] rx_len;
`ifdef MII_RX_MAC_FILTER_EN
    logic [47:0] board_mac;
`endif

    // master is the PHY/consumer side, slave is the framer itself
    modport master (
`ifdef MII_RX_MAC_FILTER_EN
        output board_mac,
`endif
        output rxdv, rxer, datain,
        input  rx_data, rx_valid, rx_sof, rx_done, frame_good, frame_bad, rx_len
    );

    modport slave (
`ifdef MII_RX_MAC_FILTER_EN
        input  board_mac,
`endif
        input  rxdv, rxer, datain,
        output rx_data, rx_valid, rx_sof, rx_done, frame_good, frame_bad, rx_len
    );
endinterface

// File: rtl/mii_frame_rx.sv
// MII receive framer: strips preamble/SFD, assembles bytes, checks CRC-32 and reports a per-frame verdict.
// Optional destination-address filter is enabled by defining MII_RX_MAC_FILTER_EN.
module mii_frame_rx #(
    parameter int MIN_FRAME = 64,
    parameter int MAX_FRAME = 1518
) (
    input  logic          clk,
    input  logic          clr,
    mii_frame_rx_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREAMBLE = 3'd1,
        DATA     = 3'd2,
        DROP     = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [10:0] MIN_LEN     = 11'(MIN_FRAME);
    localparam logic [10:0] MAX_LEN     = 11'(MAX_FRAME);
    localparam logic [10:0] LEN_SAT     = 11'h7FF;

    state_t      state;
    state_t      state_next;
    logic        phase_high;
    logic [3:0]  low_nibble;
    logic [31:0] crc;
    logic [10:0] count;
    logic        err_flag;
    logic        oversize;

    logic        start_frame;
    logic        take_low;
    logic        take_byte;
    logic        end_frame;
    logic [7:0]  byte_in;
    logic        emit_byte;
    logic        verdict_good;

    // Reflected CRC-32, data bits consumed LSB first
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in, input logic [7:0] data);
        logic [31:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) c = (c >> 1) ^ CRC_POLY;
            else                c = c >> 1;
        end
        return c;
    endfunction

    assign byte_in      = {bus.datain, low_nibble};
    assign emit_byte    = take_byte && (count < MAX_LEN);
    assign verdict_good = (crc == CRC_RESIDUE) && !err_flag && !oversize &&
                          (count >= MIN_LEN) && (count <= MAX_LEN) && !phase_high;

`ifdef MII_RX_MAC_FILTER_EN
    logic [7:0]  fifo_mem [8];
    logic [2:0]  wr_ptr;
    logic [2:0]  rd_ptr;
    logic [3:0]  level;
    logic        released;
    logic        sof_pending;
    logic        hold_good;
    logic [10:0] hold_len;
    logic [47:0] da_word;
    logic        da_match;
    logic        mac_reject;
    logic        push;
    logic        pop;
    logic        done_ready;
    logic        finish_frame;

    // The sixth DA byte is still on the nibble bus when the address decision is made
    assign da_word    = {fifo_mem[0], fifo_mem[1], fifo_mem[2], fifo_mem[3], fifo_mem[4], byte_in};
    assign da_match   = (da_word == bus.board_mac) || (da_word == 48'hFFFF_FFFF_FFFF);
    assign mac_reject = take_byte && (count == 11'd5) && !da_match;
    assign push       = emit_byte && !mac_reject;
    assign pop        = released && (level != 4'd0);
    assign done_ready = (level == 4'd0) || !released;
`endif

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next  = state;
        start_frame = 1'b0;
        take_low    = 1'b0;
        take_byte   = 1'b0;
        end_frame   = 1'b0;
`ifdef MII_RX_MAC_FILTER_EN
        finish_frame = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (bus.rxdv) state_next = (bus.datain == 4'h5) ? PREAMBLE : DROP;
            end
            PREAMBLE: begin
                if (!bus.rxdv) begin
                    state_next = IDLE;
                end else if (bus.datain == 4'hD) begin
                    state_next  = DATA;
                    start_frame = 1'b1;
                end else if (bus.datain != 4'h5) begin
                    state_next = DROP;
                end
            end
            DATA: begin
                if (!bus.rxdv) begin
                    state_next = DONE;
                    end_frame  = 1'b1;
                end else if (!phase_high) begin
                    take_low = 1'b1;
                end else begin
                    take_byte = 1'b1;
`ifdef MII_RX_MAC_FILTER_EN
                    if ((count == 11'd5) && !da_match) state_next = DROP;
`endif
                end
            end
            DROP: begin
                if (!bus.rxdv) state_next = IDLE;
            end
            DONE: begin
`ifdef MII_RX_MAC_FILTER_EN
                // Hold the verdict until the replay buffer has drained
                if (done_ready) begin
                    finish_frame = 1'b1;
                    if (bus.rxdv) state_next = (bus.datain == 4'h5) ? PREAMBLE : DROP;
                    else          state_next = IDLE;
                end
`else
                if (bus.rxdv) state_next = (bus.datain == 4'h5) ? PREAMBLE : DROP;
                else          state_next = IDLE;
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            phase_high <= 1'b0;
            low_nibble <= 4'h0;
            crc        <= CRC_INIT;
            count      <= 11'd0;
            err_flag   <= 1'b0;
            oversize   <= 1'b0;
        end else begin
            if (start_frame) begin
                phase_high <= 1'b0;
                crc        <= CRC_INIT;
                count      <= 11'd0;
                err_flag   <= 1'b0;
                oversize   <= 1'b0;
            end
            if (take_low) begin
                low_nibble <= bus.datain;
                phase_high <= 1'b1;
            end
            if (take_byte) begin
                phase_high <= 1'b0;
                crc        <= crc32_byte(crc, byte_in);
                if (count != LEN_SAT) count <= count + 11'd1;
                if (count >= MAX_LEN) oversize <= 1'b1;
            end
            if ((take_low || take_byte) && bus.rxer) err_flag <= 1'b1;
        end
    end

`ifdef MII_RX_MAC_FILTER_EN
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= byte_in;
    end

    // DA bytes wait in the buffer until the address is accepted; later bytes queue behind them
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            wr_ptr      <= 3'd0;
            rd_ptr      <= 3'd0;
            level       <= 4'd0;
            released    <= 1'b0;
            sof_pending <= 1'b0;
            hold_good   <= 1'b0;
            hold_len    <= 11'd0;
        end else begin
            if (start_frame || mac_reject || (finish_frame && !released)) begin
                wr_ptr      <= 3'd0;
                rd_ptr      <= 3'd0;
                level       <= 4'd0;
                released    <= 1'b0;
                sof_pending <= start_frame;
            end else begin
                if (push) wr_ptr <= wr_ptr + 3'd1;
                if (pop)  rd_ptr <= rd_ptr + 3'd1;
                level <= level + {3'd0, push} - {3'd0, pop};
                if (take_byte && (count == 11'd5)) released <= 1'b1;
                if (pop) sof_pending <= 1'b0;
            end
            if (end_frame) begin
                hold_good <= verdict_good;
                hold_len  <= count;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            bus.rx_data    <= 8'h00;
            bus.rx_valid   <= 1'b0;
            bus.rx_sof     <= 1'b0;
            bus.rx_done    <= 1'b0;
            bus.frame_good <= 1'b0;
            bus.frame_bad  <= 1'b0;
            bus.rx_len     <= 11'd0;
        end else begin
            bus.rx_valid   <= 1'b0;
            bus.rx_sof     <= 1'b0;
            bus.rx_done    <= 1'b0;
            bus.frame_good <= 1'b0;
            bus.frame_bad  <= 1'b0;
            bus.rx_len     <= 11'd0;
`ifdef MII_RX_MAC_FILTER_EN
            if (pop) begin
                bus.rx_valid <= 1'b1;
                bus.rx_data  <= fifo_mem[rd_ptr];
                bus.rx_sof   <= sof_pending;
            end
            if (finish_frame) begin
                bus.rx_done    <= 1'b1;
                bus.frame_good <= hold_good;
                bus.frame_bad  <= !hold_good;
                bus.rx_len     <= hold_len;
            end
`else
            if (emit_byte) begin
                bus.rx_valid <= 1'b1;
                bus.rx_data  <= byte_in;
                bus.rx_sof   <= (count == 11'd0);
            end
            if (end_frame) begin
                bus.rx_done    <= 1'b1;
                bus.frame_good <= verdict_good;
                bus.frame_bad  <= !verdict_good;
                bus.rx_len     <= count;
            end
`endif
        end
    end

endmodule
